// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the SRAM frame writer and its lane packer.
package sram_pkg;

  localparam int ADDR_WIDTH_DEF  = 18;
  localparam int PIXEL_WIDTH_DEF = 8;
  localparam int LANES           = 4;
  localparam int LANE_CNT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_SEND = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pixel_lane_packer.sv
// Packs accepted pixels into a 4-lane word and tracks which lanes were filled.
module pixel_lane_packer
  import sram_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         accept,
  input  logic                         clear,
  input  logic [PIXEL_WIDTH-1:0]       pixel,
  output logic [LANES*PIXEL_WIDTH-1:0] data,
  output logic [LANES-1:0]             mask,
  output logic                         last_lane
);

  logic [LANE_CNT_W-1:0] lane_cnt;

  // Unfilled lanes stay zero because data is cleared after every write.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane_cnt <= '0;
      data     <= '0;
      mask     <= '0;
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_cnt == LANE_CNT_W'(k)) begin
          data[k*PIXEL_WIDTH +: PIXEL_WIDTH] <= pixel;
          mask[k]                            <= 1'b1;
        end
      end
      lane_cnt <= lane_cnt + 1'b1;
    end
  end

  assign last_lane = (lane_cnt == LANE_CNT_W'(LANES - 1));

endmodule

// File: rtl/sram_frame_writer.sv
// Converts a pixel stream into 4-pixel word writes at consecutive SRAM addresses.
//   state   | meaning
//   IDLE    | waiting for the first pixel of a frame
//   PACK    | collecting pixels into the current word
//   SEND    | word presented on the write port, waiting for the arbiter
module sram_frame_writer
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        frame_base,
  input  logic                         pixel_valid,
  output logic                         pixel_ready,
  input  logic [PIXEL_WIDTH-1:0]       pixel,
  input  logic                         pixel_last,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [LANES*PIXEL_WIDTH-1:0] wr_data,
  output logic [LANES-1:0]             wr_mask,
  output logic                         frame_done,
  output logic                         busy
);

  wr_state_t             state;
  wr_state_t             state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last_word;
  logic                  last_lane;
  logic                  pixel_hs;
  logic                  wr_hs;

  assign pixel_hs = pixel_valid && pixel_ready;
  assign wr_hs    = wr_valid && wr_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pixel_hs) state_nxt = pixel_last ? ST_SEND : ST_PACK;
      ST_PACK: if (pixel_hs && (pixel_last || last_lane)) state_nxt = ST_SEND;
      ST_SEND: if (wr_ready) state_nxt = last_word ? ST_IDLE : ST_PACK;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pixel_ready = 1'b0;
    wr_valid    = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        pixel_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_PACK: pixel_ready = 1'b1;
      ST_SEND: wr_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // last_word remembers whether the word in flight closes the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr       <= '0;
      last_word  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wr_hs && last_word;
      if (state == ST_IDLE && pixel_hs) addr <= frame_base;
      else if (wr_hs)                   addr <= addr + 1'b1;
      if (pixel_hs) last_word <= pixel_last;
    end
  end

  assign wr_addr = addr;

  pixel_lane_packer #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_packer (
    .clock    (clock),
    .reset    (reset),
    .accept   (pixel_hs),
    .clear    (wr_hs),
    .pixel    (pixel),
    .data     (wr_data),
    .mask     (wr_mask),
    .last_lane(last_lane)
  );

endmodule

// File: tb/tb_sram_frame_writer.sv
// Randomized checks of sram_frame_writer against a word-level model of the frame layout.
module tb_sram_frame_writer;

  localparam int AW = 18;
  localparam int PW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] frame_base;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [PW-1:0] pixel;
  logic          pixel_last;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic          frame_done;
  logic          busy;

  always #5 clock = ~clock;

  sram_frame_writer #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_base (frame_base),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel      (pixel),
    .pixel_last (pixel_last),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .frame_done (frame_done),
    .busy       (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    mask;
    int            cyc;
  } wr_t;

  wr_t          obs[$];
  wr_t          exp_q[$];
  logic [PW-1:0] pix[$];
  int           done_cnt = 0;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  int           rdy_mode = 0;  // 0: ready high, 1: random, 2: driven by the test

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // wr_ready driven at the falling edge, handshakes observed 2 time units later.
  initial forever begin : monitor
    wr_t w;
    @(negedge clock);
    if (rdy_mode == 0)      wr_ready = 1'b1;
    else if (rdy_mode == 1) wr_ready = 1'($urandom_range(0, 1));
    #2;
    if (!reset && wr_valid && wr_ready) begin
      w.addr = wr_addr;
      w.data = wr_data;
      w.mask = wr_mask;
      w.cyc  = cyc;
      obs.push_back(w);
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    obs.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  // Frame layout model: pixel i lands in word i/4, lane i%4, at base + i/4 mod 2^AW.
  task automatic add_expected(input logic [AW-1:0] base, input int n);
    wr_t e;
    for (int w = 0; w < (n + 3) / 4; w++) begin
      e.addr = base + AW'(w);
      e.data = '0;
      e.mask = '0;
      e.cyc  = 0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < n) begin
          e.data = e.data | (32'(pix[w*4+l]) << (8 * l));
          e.mask[l] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic push_pixel(input logic [PW-1:0] p, input logic last, input logic [AW-1:0] base);
    int guard = 0;
    frame_base  = base;
    pixel       = p;
    pixel_last  = last;
    pixel_valid = 1'b1;
    while (!pixel_ready && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: pixel_ready=%b required 1 within 300 cycles", pixel_ready);
    end
    @(negedge clock);
    pixel_valid = 1'b0;
    pixel_last  = 1'b0;
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int n, input bit gaps);
    add_expected(base, n);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
      push_pixel(pix[i], i == n - 1, (i == 0) ? base : AW'($urandom));
    end
  endtask

  task automatic check_writes(input string name, input int n_done);
    int guard = 0;
    int n;
    while (done_cnt < n_done && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (done_cnt !== n_done) begin
      errors++;
      $display("FAIL %s_frame_done: got %0d pulses, expected %0d", name, done_cnt, n_done);
    end
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d writes, expected %0d", name, obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL %s_addr[%0d]: got %h expected %h", name, i, obs[i].addr, exp_q[i].addr);
      end
      checks++;
      if (obs[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h expected %h", name, i, obs[i].data, exp_q[i].data);
      end
      checks++;
      if (obs[i].mask !== exp_q[i].mask) begin
        errors++;
        $display("FAIL %s_mask[%0d]: got %b expected %b", name, i, obs[i].mask, exp_q[i].mask);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({wr_valid, frame_done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got valid/done/busy=%b expected 000", {wr_valid, frame_done, busy});
    end
    checks++;
    if (wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0", wr_addr);
    end
    checks++;
    if (wr_data !== '0 || wr_mask !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%b expected 0/0", wr_data, wr_mask);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (pixel_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_pixel_ready: got %b expected 1", pixel_ready);
    end
  endtask

  task automatic test_basic();
    clear_log();
    rdy_mode = 0;
    pix.delete();
    for (int i = 1; i <= 8; i++) pix.push_back(PW'(i));
    run_frame(18'h100, 8, 1'b0);
    check_writes("basic", 1);
    checks++;
    if (obs.size() >= 2 && obs[1].cyc - obs[0].cyc !== 5) begin
      errors++;
      $display("FAIL basic_throughput: got %0d cycles between writes, expected 5", obs[1].cyc - obs[0].cyc);
    end
    checks++;
    if (obs.size() < 1 || obs[0].data !== 32'h04030201) begin
      errors++;
      $display("FAIL basic_word0: got %0d writes, expected word 04030201 first", obs.size());
    end
  endtask

  task automatic test_partial();
    clear_log();
    pix.delete();
    for (int i = 0; i < 6; i++) pix.push_back(8'hA0 + PW'(i));
    run_frame(18'h2345, 6, 1'b1);
    check_writes("partial", 1);
    checks++;
    if (obs.size() < 2 || obs[1].data !== 32'h0000A5A4 || obs[1].mask !== 4'b0011) begin
      errors++;
      $display("FAIL partial_tail: got %0d writes, expected tail 0000a5a4/0011", obs.size());
    end
  endtask

  task automatic test_single_lane();
    clear_log();
    pix.delete();
    for (int i = 0; i < 5; i++) pix.push_back(PW'($urandom));
    run_frame(18'h0777, 5, 1'b0);
    check_writes("single_lane", 1);
    checks++;
    if (obs.size() < 2 || obs[1].mask !== 4'b0001) begin
      errors++;
      $display("FAIL single_lane_mask: got %0d writes, expected second mask 0001", obs.size());
    end
  endtask

  task automatic test_stall();
    clear_log();
    rdy_mode = 2;
    wr_ready = 1'b0;
    pix.delete();
    for (int i = 0; i < 4; i++) pix.push_back(8'h11 + PW'(i));
    run_frame(18'h200, 4, 1'b0);
    checks++;
    if (wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_latency: got wr_valid=%b expected 1 one cycle after last pixel", wr_valid);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (wr_valid !== 1'b1 || pixel_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ctrl[%0d]: got valid/ready=%b%b expected 10", c, wr_valid, pixel_ready);
      end
      checks++;
      if (wr_addr !== 18'h200 || wr_data !== 32'h14131211 || wr_mask !== 4'hF) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h/%h/%b expected 00200/14131211/1111", c, wr_addr, wr_data, wr_mask);
      end
      @(negedge clock);
    end
    wr_ready = 1'b1;
    @(negedge clock);
    wr_ready = 1'b0;
    check_writes("stall", 1);
    rdy_mode = 0;
  endtask

  task automatic test_wrap();
    clear_log();
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(PW'($urandom));
    run_frame(18'h3FFFF, 8, 1'b0);
    check_writes("wrap", 1);
    checks++;
    if (obs.size() < 2 || obs[0].addr !== 18'h3FFFF || obs[1].addr !== 18'h00000) begin
      errors++;
      $display("FAIL wrap_addr: got %0d writes, expected addresses 3ffff then 00000", obs.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    push_pixel(8'h55, 1'b0, 18'h300);
    push_pixel(8'h66, 1'b0, 18'h301);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (obs.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_discard: got %0d writes busy=%b, expected 0 writes busy=0", obs.size(), busy);
    end
    pix.delete();
    for (int i = 0; i < 4; i++) pix.push_back(8'hC1 + PW'(i));
    run_frame(18'h50, 4, 1'b0);
    check_writes("reset_mid", 1);
  endtask

  task automatic test_back_to_back();
    clear_log();
    pix.delete();
    for (int i = 0; i < 4; i++) pix.push_back(PW'($urandom));
    run_frame(18'h10, 4, 1'b0);
    pix.delete();
    for (int i = 0; i < 4; i++) pix.push_back(PW'($urandom));
    run_frame(18'h40, 4, 1'b0);
    check_writes("back_to_back", 2);
  endtask

  task automatic test_random();
    int n;
    logic [AW-1:0] base;
    rdy_mode = 1;
    for (int f = 0; f < 12; f++) begin
      clear_log();
      n = (f == 0) ? 1 : int'($urandom_range(1, 13));
      base = AW'($urandom);
      pix.delete();
      for (int i = 0; i < n; i++) pix.push_back(PW'($urandom));
      run_frame(base, n, 1'b1);
      check_writes("random", 1);
    end
    rdy_mode = 0;
  endtask

  initial begin
    reset       = 1'b1;
    frame_base  = '0;
    pixel_valid = 1'b0;
    pixel       = '0;
    pixel_last  = 1'b0;
    wr_ready    = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_partial();
    test_single_lane();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
